mux_rr_sched: RTL

- Parametrised N-channel, SIZE-bit selector with a registered output stage and valid/ready handshakes on every channel and on the output.
- Two selection modes: manual (channel chosen by S) and round-robin (fair scan over valid channels).
- Replaces fixed 4:1 combinational muxing in the datapath wherever operands arrive from several producers that can stall, e.g. feeding Fibonacci adder operands from multiple sources.

---
 rtl/mux_rr_sched_if.sv | 27 ++
 rtl/mux_rr_sched.sv | 70 +++++++
 2 files changed

// File: rtl/mux_rr_sched_if.sv
// Handshake bundle for mux_rr_sched: CH producer channels in, one registered word out.
// The producer/consumer side uses master; the selector itself uses slave.
interface mux_rr_sched_if #(
    parameter int SIZE = 4,
    parameter int CH   = 4,
    parameter int SELW = 2
) ();
    logic [CH*SIZE-1:0] in_data;
    logic [CH-1:0]      in_valid;
    logic [CH-1:0]      in_ready;
    logic [SELW-1:0]    S;
    logic               mode;
    logic [SIZE-1:0]    mux_out;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    out_ch;

    modport master (
        output in_data, in_valid, S, mode, out_ready,
        input  in_ready, mux_out, out_valid, out_ch
    );

    modport slave (
        input  in_data, in_valid, S, mode, out_ready,
        output in_ready, mux_out, out_valid, out_ch
    );
endinterface

// File: rtl/mux_rr_sched.sv
// N-channel selector with a one-word registered output stage; manual or round-robin choice.
// The round-robin pointer remembers the last granted channel in either mode.
module mux_rr_sched #(
    parameter int SIZE = 4,
    parameter int CH   = 4,
    parameter int SELW = 2
) (
    input  logic           clk,
    input  logic           reset,
    mux_rr_sched_if.slave  bus
);
    localparam logic [SELW-1:0] LAST = SELW'(CH - 1);

    logic [SIZE-1:0] mux_out_r;
    logic [SELW-1:0] out_ch_r;
    logic            out_valid_r;
    logic [SELW-1:0] ptr;

    logic            load_en;
    logic            cand_found;
    logic [SELW-1:0] cand;
    logic [SELW-1:0] idx;
    logic            grant;

    assign load_en = !out_valid_r || bus.out_ready;

    always_comb begin
        cand_found = 1'b0;
        cand       = '0;
        idx        = ptr;
        if (!bus.mode) begin
            if (32'(bus.S) < CH) begin
                cand_found = 1'b1;
                cand       = bus.S;
            end
        end else begin
            // Scan starts one past the last grant and wraps explicitly at CH-1.
            for (int i = 0; i < CH; i++) begin
                idx = (idx == LAST) ? '0 : idx + 1'b1;
                if (!cand_found && bus.in_valid[idx]) begin
                    cand_found = 1'b1;
                    cand       = idx;
                end
            end
        end
    end

    assign grant        = !reset && load_en && cand_found && bus.in_valid[cand];
    assign bus.in_ready = grant ? (CH'(1) << cand) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            mux_out_r   <= '0;
            out_ch_r    <= '0;
            out_valid_r <= 1'b0;
            ptr         <= LAST;
        end else if (grant) begin
            mux_out_r   <= bus.in_data[int'(cand)*SIZE +: SIZE];
            out_ch_r    <= cand;
            out_valid_r <= 1'b1;
            ptr         <= cand;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.mux_out   = mux_out_r;
    assign bus.out_ch    = out_ch_r;
    assign bus.out_valid = out_valid_r;
endmodule
